regfile_2r1w: RTL
=================

// Module: regfile_2r1w
// PURPOSE
//  Parametrised register file for the CPU datapath, replacing discrete register+mux trees.
//  Two registered read ports and one write port.
//  Optional hard-wired zero register and optional write-to-read bypass.
//  Built-in clear sequencer zeroes storage after reset or on request, so the array needs no
//  per-entry reset and can map to block/distributed RAM.
// PARAMETERS
//  WIDTH    32  data width in bits
//  ABITS    4   address width; DEPTH = 2**ABITS entries
//  ZERO_R0  1   1: entry 0 always reads 0 and writes to it are discarded
//  BYPASS   1   1: same-cycle write data forwarded to a read of the same address
// PORTS
//  clk      in   1      clock, all state on rising edge
//  reset    in   1      asynchronous, active-high reset
//  clr      in   1      request a full clear sweep (sampled only when busy=0)
//  busy     out  1      clear sweep in progress; writes ignored, reads return 0
//  wen      in   1      write enable
//  waddr    in   ABITS  write address
//  wdata    in   WIDTH  write data
//  raddr_a  in   ABITS  read port A address
//  rdata_a  out  WIDTH  read port A data, 1-cycle latency
//  raddr_b  in   ABITS  read port B address
//  rdata_b  out  WIDTH  read port B data, 1-cycle latency
// BEHAVIOUR
//  Reset (async assert): rdata_a=rdata_b=0, busy=1, state=CLEAR, clear counter cnt=0.
//    Array contents are not reset directly.
//  FSM states:
//    IDLE:  clr=1 at an edge -> CLEAR; cnt=0, busy=1 after that edge.
//    CLEAR: each edge writes 0 to mem[cnt] and increments cnt.
//           The edge with cnt==DEPTH-1 returns to IDLE; busy=0 after it.
//  Sweep timing:
//    After reset release, edges 1..DEPTH clear entries 0..DEPTH-1; busy falls after edge DEPTH.
//    After clr is accepted at edge 0, edges 1..DEPTH clear entries 0..DEPTH-1;
//    busy falls after edge DEPTH.
//  clr while busy=1: ignored; the sweep does not restart and is not extended.
//  Write (IDLE only): wen=1 -> mem[waddr] <= wdata at the edge.
//    ZERO_R0=1 and waddr==0: write discarded.
//    wen with busy=1: discarded.
//    wen and clr in the same IDLE cycle: the write lands, then the sweep zeroes it.
//  Read, each port independently, registered at every edge:
//    busy=1                             -> rdata <= 0
//    ZERO_R0=1 and raddr==0             -> rdata <= 0
//    BYPASS=1, wen=1, waddr==raddr
//      (write accepted this cycle)      -> rdata <= wdata
//    otherwise                          -> rdata <= mem[raddr], the pre-edge contents
//                                          (BYPASS=0 gives old data on collision)
//  Both ports may read the same address; results are identical.
//  No address wrap or overflow; all ABITS addresses are valid.
//  cnt is ABITS wide and wraps only on the terminal edge, which coincides with leaving CLEAR.
//  Reset asserted mid-sweep or mid-write: immediately re-enter the reset state above;
//    a full sweep follows release.
// TESTING
//  1. Reset, WIDTH=32, ABITS=4: busy=1 for exactly 16 edges after release.
//     Then read all 16 entries -> all 0.
//  2. Write 0xDEADBEEF to addr 5, next cycle raddr_a=5 -> rdata_a=0xDEADBEEF one edge later.
//     Write 0x1234 to addr 0 -> reads of addr 0 return 0 (ZERO_R0=1).
//  3. Same-cycle wen=1 waddr=3 wdata=0xA5A5A5A5 and raddr_b=3:
//     BYPASS=1 -> rdata_b=0xA5A5A5A5; BYPASS=0 -> previous contents.
//  4. Fill entries 1..15 with their index, pulse clr:
//     busy=1 for 16 edges, wen during busy discarded, rdata=0 during busy; afterwards all entries read 0.
//  5. Assert reset at sweep count 7 after clr: outputs 0 and busy=1 at once.
//     After release a full 16-edge sweep runs. clr pulsed mid-sweep does not lengthen busy.
//  6. Random wen/raddr traffic, 10k cycles, against a reference model for ZERO_R0/BYPASS in {0,1}^2:
//     zero mismatches.

Source files
------------

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with registered reads, optional hard-wired zero
// entry and write bypass. A clear sweep zeroes the array after reset or on request.
module regfile_2r1w #(
  parameter int WIDTH   = 32,
  parameter int ABITS   = 4,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic             busy,
  input  logic             wen,
  input  logic [ABITS-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ABITS-1:0] raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [ABITS-1:0] raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  // state | meaning
  // IDLE  | normal operation, reads and writes serviced
  // CLEAR | sweeping zeroes into mem[cnt], one entry per edge
  localparam int DEPTH = 2 ** ABITS;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [ABITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_acc;

  assign busy    = (state_q == CLEAR);
  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign wr_acc  = (state_q == IDLE) && wen && !(ZERO_R0 && (waddr == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ABITS{1'b1}}) state_d = IDLE;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Read data is taken from the pre-edge array; bypass forwards an accepted write.
  function automatic logic [WIDTH-1:0] rd_sel(input logic [ABITS-1:0] raddr);
    logic [WIDTH-1:0] r;
    r = mem_q[raddr];
    if (BYPASS && wr_acc && (waddr == raddr)) r = wdata;
    if (ZERO_R0 && (raddr == '0)) r = '0;
    if (state_q == CLEAR) r = '0;
    return r;
  endfunction

  always_comb begin
    rdata_a_d = rd_sel(raddr_a);
    rdata_b_d = rd_sel(raddr_b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  // No reset on the array so it can map onto RAM; the sweep provides the zeroing.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem_q[cnt_q] <= '0;
    else if (wr_acc)      mem_q[waddr] <= wdata;
  end

endmodule
